dmem_arbiter: RTL and testbench

Two-port arbiter in front of the single-port data memory. It shares that memory between the core load/store unit (M0) and a DMA/debug requester (M1). It grants at most one access per cycle and drives the memory's read/write controls. It also returns registered read data to the winning requester. The memory has a combinational read and writes on the clock edge. This block therefore adds exactly one cycle of read latency and no write latency.

---
 rtl/dmem_arb_pkg.sv | 29 ++
 rtl/dmem_arb_pick.sv | 68 ++++++
 rtl/dmem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
//
// Shared definitions for the data-memory arbiter:
//   - owner_e    : which requester was granted in the previous cycle
//   - *_DEF      : default address/data widths and burst limit
//   - cnt_width(): width of the saturating burst counter (holds 0..MAX_BURST)
//
// Build option: DMEM_ARB_RR_EN (see dmem_arb_pick) selects burst-limited
// rotation; when undefined the arbiter uses fixed priority (M0 wins).
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

    localparam int ADDR_W_DEF    = 32;
    localparam int DATA_W_DEF    = 32;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_e;

    // Counter must represent MAX_BURST itself, hence the +1.
    function automatic int cnt_width(input int max_burst);
        return (max_burst < 1) ? 1 : $clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// ----------------------------------------------------------------------------
// dmem_arb_pick
//
// Pure combinational grant selection for the two-master data-memory arbiter.
// Produces a one-hot-or-zero grant vector from the previous owner, the
// current burst count and the two request lines.
//
// Ports:
//   owner  in  owner_e       owner granted in the previous cycle
//   cnt    in  [CNT_W-1:0]   consecutive grants to that owner (saturating)
//   req    in  [1:0]         {m1_req, m0_req}
//   gnt    out [1:0]         {m1_gnt, m0_gnt}, never both set
//
// Build option DMEM_ARB_RR_EN:
//   defined   - burst-limited rotation: the current owner keeps the memory
//               while cnt < MAX_BURST, then yields to a waiting master.
//   undefined - fixed priority: M0 always wins a contested cycle; owner and
//               cnt are accepted but not consulted.
// ----------------------------------------------------------------------------
import dmem_arb_pkg::*;

module dmem_arb_pick #(
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int CNT_W     = cnt_width(MAX_BURST)
) (
    input  owner_e           owner,
    input  logic [CNT_W-1:0] cnt,
    input  logic [1:0]       req,
    output logic [1:0]       gnt
);

`ifdef DMEM_ARB_RR_EN
    // Burst budget of the current owner is used up.
    logic burst_done;
    assign burst_done = (cnt == CNT_W'(MAX_BURST));

    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                unique case (owner)
                    OWN0:    gnt = burst_done ? 2'b10 : 2'b01;
                    OWN1:    gnt = burst_done ? 2'b01 : 2'b10;
                    default: gnt = 2'b01;   // nobody owned last cycle: M0 first
                endcase
            end
            default: gnt = 2'b00;
        endcase
    end
`else
    // Fixed priority ignores history; fold it into a dummy so the inputs
    // stay on the port list for drop-in swapping with the rotating variant.
    logic unused_fixed;
    assign unused_fixed = ^{owner, cnt, CNT_W'(MAX_BURST)};

    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares a single-port data memory (combinational read, write on clock edge)
// between the core load/store unit (M0) and a DMA/debug requester (M1).
// At most one access is granted per cycle, in the same cycle as the request.
// Reads return through one shared registered data word one cycle after the
// grant; writes complete on the edge that ends the grant cycle.
//
// Parameters: ADDR_W, DATA_W, MAX_BURST (>=1)
//
// Ports:
//   clk                 in   single clock, rising edge
//   rst_n               in   synchronous active-low reset
//   m0_req / m1_req     in   request, held until granted
//   m0_we  / m1_we      in   1 = write, 0 = read
//   m0_addr/ m1_addr    in   byte address, passed through unmodified
//   m0_wdata/m1_wdata   in   write data
//   m0_gnt / m1_gnt     out  access performed this cycle (combinational)
//   m0_rvalid/m1_rvalid out  read data valid, one cycle after a read grant
//   m0_rdata/ m1_rdata  out  shared read data register, qualified by rvalid
//   mem_read/mem_write  out  memory strobes
//   mem_addr/mem_wdata  out  muxed address / write data (0 when idle)
//   mem_rdata           in   memory read data (combinational)
//
// Build option DMEM_ARB_RR_EN: burst-limited rotation instead of fixed
// M0 priority (selected inside dmem_arb_pick).
// ----------------------------------------------------------------------------
import dmem_arb_pkg::*;

module dmem_arbiter #(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W   = cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    owner_e            owner_reg, owner_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
    logic [1:0]        rvalid_reg, rvalid_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;

    logic [1:0]        req_vec;
    logic [1:0]        pick_gnt;
    logic [1:0]        gnt;
    logic [1:0]        rvalid_out;

    assign req_vec = {m1_req, m0_req};

    dmem_arb_pick #(
        .MAX_BURST (MAX_BURST),
        .CNT_W     (CNT_W)
    ) u_pick (
        .owner (owner_reg),
        .cnt   (cnt_reg),
        .req   (req_vec),
        .gnt   (pick_gnt)
    );

    // Reset masks grants combinationally so no memory write can slip through
    // in a reset cycle, and masks rvalid so a read response already queued
    // for the cycle in which reset arrives is dropped rather than delivered.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_port
        assign gnt[gi]        = pick_gnt[gi]   & rst_n;
        assign rvalid_out[gi] = rvalid_reg[gi] & rst_n;
    end

    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_reg  <= IDLE;
            cnt_reg    <= '0;
            rvalid_reg <= 2'b00;
            rdata_reg  <= '0;
        end else begin
            owner_reg  <= owner_next;
            cnt_reg    <= cnt_next;
            rvalid_reg <= rvalid_next;
            rdata_reg  <= rdata_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        owner_next  = IDLE;
        cnt_next    = '0;
        rvalid_next = 2'b00;
        rdata_next  = rdata_reg;

        if (gnt[0]) begin
            owner_next = OWN0;
            cnt_next   = (owner_reg == OWN0) ? cnt_inc : CNT_ONE;
        end else if (gnt[1]) begin
            owner_next = OWN1;
            cnt_next   = (owner_reg == OWN1) ? cnt_inc : CNT_ONE;
        end

        // Capture the memory's combinational read data and steer the
        // response strobe to whichever master was granted the read.
        if (mem_read) begin
            rdata_next  = mem_rdata;
            rvalid_next = gnt;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        m0_gnt    = gnt[0];
        m1_gnt    = gnt[1];
        m0_rvalid = rvalid_out[0];
        m1_rvalid = rvalid_out[1];
        m0_rdata  = rdata_reg;
        m1_rdata  = rdata_reg;

        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        if (gnt[0]) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_write = m0_we;
            mem_read  = ~m0_we;
        end else if (gnt[1]) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_write = m1_we;
            mem_read  = ~m1_we;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Scoreboard bench for dmem_arbiter. A driver applies one directed vector per
// cycle and pushes the hand-computed grant/memory-control expectation plus,
// for read grants, the expected read response. A separate monitor on the
// falling edge pops and compares. A small word-addressed memory model
// (combinational read, write on rising edge) sits behind the arbiter.
// Expected grant patterns follow DMEM_ARB_RR_EN when it is defined.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_dmem_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory model: word i initialised to 0xA000_0000 | i.
    logic [31:0] mem [0:255];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
    end
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:2]] = mem_wdata;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  gnt;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        string       tag;
    } exp_t;

    typedef struct {
        int          due;
        bit          who;     // 0 = M0, 1 = M1
        logic [31:0] data;
        string       tag;
    } rsp_t;

    exp_t exp_q[$];
    rsp_t rsp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // One cycle of stimulus with its expectation.
    task automatic step(input logic rst,
                        input logic r0, input logic w0,
                        input logic [31:0] a0, input logic [31:0] d0,
                        input logic r1, input logic w1,
                        input logic [31:0] a1, input logic [31:0] d1,
                        input logic [1:0] egnt, input logic erv,
                        input logic [31:0] edata, input string tag);
        exp_t e;
        rsp_t r;
        @(posedge clk);
        #1;
        rst_n = rst;
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
        e.gnt = egnt; e.tag = tag;
        e.rd = 1'b0; e.wr = 1'b0; e.addr = '0; e.wdata = '0;
        if (egnt[0]) begin
            e.rd = ~w0; e.wr = w0; e.addr = a0; e.wdata = d0;
        end else if (egnt[1]) begin
            e.rd = ~w1; e.wr = w1; e.addr = a1; e.wdata = d1;
        end
        exp_q.push_back(e);
        if (erv) begin
            r.due = cyc + 1; r.who = egnt[1]; r.data = edata; r.tag = tag;
            rsp_q.push_back(r);
        end
    endtask

    task automatic idle(input string tag);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
             2'b00, 1'b0, 32'h0, tag);
    endtask

    // Monitor: compares this cycle's grant/memory controls and any response.
    initial begin
        exp_t e;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("cyc %0d %s gnt=%b rd=%b wr=%b addr=%h",
                         cyc, e.tag, {m1_gnt, m0_gnt}, mem_read, mem_write, mem_addr);
                chk({e.tag, ".gnt"},   {30'd0, m1_gnt, m0_gnt},     {30'd0, e.gnt});
                chk({e.tag, ".ctl"},   {30'd0, mem_read, mem_write}, {30'd0, e.rd, e.wr});
                chk({e.tag, ".addr"},  mem_addr,  e.addr);
                chk({e.tag, ".wdata"}, mem_wdata, e.wdata);
            end
            if (m0_rvalid || m1_rvalid) begin
                if (rsp_q.size() == 0) begin
                    chk("rvalid_unexpected", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    $display("cyc %0d rsp %s m%0d data=%h", cyc, r.tag, r.who,
                             r.who ? m1_rdata : m0_rdata);
                    chk({r.tag, ".rvalid"}, {30'd0, m1_rvalid, m0_rvalid},
                        r.who ? 32'd2 : 32'd1);
                    chk({r.tag, ".rdata"}, r.who ? m1_rdata : m0_rdata, r.data);
                    chk({r.tag, ".rcyc"},  r.due, cyc);
                end
            end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                r = rsp_q.pop_front();
                chk({r.tag, ".rvalid_missing"}, 32'd0, 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] g;
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;

        // Reset, even with M0 trying to write.
        step(1'b0, 1'b1, 1'b1, 32'h10, 32'h5555_5555, 1'b0, 1'b0, 32'h0, 32'h0,
             2'b00, 1'b0, 32'h0, "rst_wr");
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
             2'b00, 1'b0, 32'h0, "rst");
        idle("post_rst");
        chk("reset.rdata",  m0_rdata, 32'h0);
        chk("reset.rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);

        // M0 write, M1 reads it back.
        step(1'b1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 32'h0,
             2'b01, 1'b0, 32'h0, "m0_wr");
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h10, 32'h0,
             2'b10, 1'b1, 32'hDEAD_BEEF, "m1_rd");
        idle("idle1");

        // Both read continuously from IDLE.
        for (int i = 0; i < 10; i++) begin
            g = (RR && i >= 4 && i < 8) ? 2'b10 : 2'b01;
            step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0,
                 g, 1'b1, g[1] ? 32'hA000_0020 : 32'hA000_0010, "burst");
        end
        idle("idle2");

        // M0 at cnt=2 drops req; M1 wins at once with cnt=1.
        step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
             2'b01, 1'b1, 32'hA000_0010, "drop_a");
        step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0,
             2'b01, 1'b1, 32'hA000_0010, "drop_b");
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0,
             2'b10, 1'b1, 32'hA000_0020, "drop_c");
        for (int i = 0; i < 4; i++) begin
            g = (RR && i < 3) ? 2'b10 : 2'b01;
            step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0,
                 g, 1'b1, g[1] ? 32'hA000_0020 : 32'hA000_0010, "cnt1");
        end
        idle("idle3");

        // Read at N, reset at N+1: response dropped, write blocked.
        step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
             2'b01, 1'b0, 32'h0, "rd_then_rst");
        step(1'b0, 1'b1, 1'b1, 32'h40, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 32'h0,
             2'b00, 1'b0, 32'h0, "rst_mid");
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
             2'b00, 1'b0, 32'h0, "rst_mid2");
        idle("post_rst2");
        chk("reset2.rdata", m0_rdata, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
             2'b01, 1'b1, 32'hA000_0010, "no_wr_in_rst");
        idle("idle4");

        // Idle then simultaneous writes: M0 wins, then M1.
        step(1'b1, 1'b1, 1'b1, 32'h20, 32'h1111_1111, 1'b1, 1'b1, 32'h24, 32'h2222_2222,
             2'b01, 1'b0, 32'h0, "both_wr");
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h24, 32'h2222_2222,
             2'b10, 1'b0, 32'h0, "m1_wr");
        step(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
             2'b01, 1'b1, 32'h1111_1111, "rb_20");
        step(1'b1, 1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
             2'b01, 1'b1, 32'h2222_2222, "rb_24");
        idle("tail1");
        idle("tail2");

        @(negedge clk);
        #1;
        chk("exp_q.left", exp_q.size(), 32'd0);
        chk("rsp_q.left", rsp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
